change_dispenser: RTL
=====================

# change_dispenser

Sequential controller that pays out change for the vending machine. It takes a change amount, dispenses coins and bills one at a time to the coin-return mechanism using a greedy largest-first selection, and tracks per-denomination inventory. It sits between the transaction logic, which computes change on vend or cancel, and the physical dispenser. It also produces per-transaction tallies for the coin-return display.

## Interface
Parameters:
- AMT_W, 8, width of amount, shortfall and tallies; unit = 5 cents
- INV_W, 8, width of each inventory counter
- INIT_INV, 20, per-denomination inventory loaded at reset and on refill
- ACK_TIMEOUT, 1023, maximum cycles to wait for coin_ack before giving up on a denomination

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  change request present
- req_ready  out  1  high only in IDLE
- req_amount  in  AMT_W  change owed, in 5-cent units
- coin_ack  in  1  dispenser confirms one item ejected
- eject  out  5  one-hot eject pulse: bit4 $5, bit3 $1, bit2 25c, bit1 10c, bit0 5c
- refill  in  1  single-cycle pulse that restores all inventory to INIT_INV
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a transaction ends
- shortfall  out  AMT_W  amount left unpaid by the last transaction
- fault  out  1  sticky; set on any ack timeout
- tally_five, tally_dollar, tally_quarter, tally_dime, tally_nickel  out  AMT_W each  items paid in the current or last transaction

## Operation
- Denomination values in units: $5 = 100, $1 = 20, 25c = 5, 10c = 2, 5c = 1. There is one INV_W inventory counter per denomination.
- FSM states: IDLE, SELECT, EJECT, WAIT_ACK, DONE.
- IDLE
  - On req_valid && req_ready: capture req_amount into remaining, clear all tallies, go to SELECT.
- SELECT
  - If remaining == 0: set shortfall = 0 and go to DONE.
  - Otherwise pick the highest denomination d with value(d) <= remaining and inv[d] > 0, latch d, and go to EJECT.
  - If no such d exists: set shortfall = remaining and go to DONE.
- EJECT
  - Drive eject = onehot(d) for exactly one cycle.
  - Clear the timeout counter and go to WAIT_ACK.
- WAIT_ACK
  - On coin_ack: remaining -= value(d), inv[d] -= 1, tally[d] += 1, then go to SELECT.
  - Otherwise increment the timeout counter. When it reaches ACK_TIMEOUT: force inv[d] = 0, set fault, go to SELECT. The next smaller denomination is then tried.
- DONE
  - Pulse done, then go to IDLE.
  - shortfall and the tallies hold their values until the next accepted request.
- coin_ack is ignored in every state except WAIT_ACK.
- refill is honoured only in IDLE: every inv is set to INIT_INV and fault is cleared. refill is ignored when busy.
- refill and req_valid arriving in the same IDLE cycle: both take effect, and SELECT sees the refilled inventory.
- Arithmetic never underflows, because selection guarantees value(d) <= remaining and inv[d] > 0.
- Tallies cannot overflow, because each tally is at most req_amount.

## Timing
- Reset values:
  - state = IDLE, req_ready = 1.
  - busy, done, fault = 0; eject = 0.
  - shortfall and all tallies = 0.
  - every inv = INIT_INV.
- Reset is asynchronous and takes effect mid-transaction from any state. Any pending coin is abandoned and is not counted.
- Request accept at cycle 0 puts the FSM in SELECT at cycle 1.
- Each item costs at least 3 cycles (SELECT, EJECT, WAIT_ACK), with coin_ack sampled no earlier than the cycle after the eject pulse.
- With N items and immediate acks, done is high at cycle 3N + 2.
- A zero amount gives done at cycle 2 with no eject.
- eject is never high in two consecutive cycles.
- At most one eject bit is high at any time.

## Test plan
- **Full payout:** INIT_INV = 20, req_amount = 28 ($1.40), coin_ack in every WAIT_ACK cycle.
  - eject sequence: 01000, 00100, 00010, 00001.
  - Tallies 0/1/1/1/1; shortfall 0; done at cycle 14.
- **Depletion and shortfall:** INIT_INV = 1. Request 2, then request 2.
  - First request: one dime.
  - Second request: one nickel, then shortfall = 1, tally_nickel = 1.
- **Timeout:** ACK_TIMEOUT = 15, req_amount = 5, coin_ack withheld for the 25c item.
  - After 15 cycles: fault = 1 and quarter inventory = 0.
  - Payout continues as dime, dime, nickel with acks; shortfall = 0.
- **Zero amount:** req_amount = 0.
  - done at cycle 2, eject stays 0, tallies read 0.
- **Reset mid-operation:** assert rst_n low while in WAIT_ACK.
  - All outputs return to their reset values immediately.
  - Every inventory counter is back at INIT_INV; req_ready = 1.
- **Refill gating:** pulse refill while busy and check inventory is unchanged. Then pulse refill in IDLE after a fault.
  - fault clears and all inventory = INIT_INV.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the vending transaction logic and the
// change dispenser.
interface change_dispenser_if #(
  parameter int AMT_W = 8
) ();
  logic             req_valid;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount;
  logic             coin_ack;
  logic [4:0]       eject;
  logic             refill;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] shortfall;
  logic             fault;
  logic [AMT_W-1:0] tally_five;
  logic [AMT_W-1:0] tally_dollar;
  logic [AMT_W-1:0] tally_quarter;
  logic [AMT_W-1:0] tally_dime;
  logic [AMT_W-1:0] tally_nickel;

  modport master (
    output req_valid, req_amount, coin_ack, refill,
    input  req_ready, eject, busy, done, shortfall, fault,
           tally_five, tally_dollar, tally_quarter, tally_dime, tally_nickel
  );

  modport slave (
    input  req_valid, req_amount, coin_ack, refill,
    output req_ready, eject, busy, done, shortfall, fault,
           tally_five, tally_dollar, tally_quarter, tally_dime, tally_nickel
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy largest-first change payout FSM with per-denomination inventory,
// ack timeout fallback and per-transaction tallies.
module change_dispenser #(
  parameter int AMT_W       = 8,
  parameter int INV_W       = 8,
  parameter int INIT_INV    = 20,
  parameter int ACK_TIMEOUT = 1023
) (
  input logic               clk,
  input logic               rst_n,
  change_dispenser_if.slave bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EJECT, S_WAIT_ACK, S_DONE} state_t;

  state_t                     r_state, w_next;
  logic [AMT_W-1:0]           r_rem;
  logic [2:0]                 r_sel;
  logic [4:0][INV_W-1:0]      r_inv;
  logic [4:0][AMT_W-1:0]      r_tally;
  logic [AMT_W-1:0]           r_short;
  logic                       r_fault;
  logic [TW-1:0]              r_tmo;
  logic                       w_found;
  logic [2:0]                 w_pick;
  logic                       w_tmo_hit;

  // Index 4..0 = $5, $1, 25c, 10c, 5c; matches the eject bit order.
  function automatic logic [AMT_W-1:0] val(input logic [2:0] i);
    case (i)
      3'd4:    val = AMT_W'(100);
      3'd3:    val = AMT_W'(20);
      3'd2:    val = AMT_W'(5);
      3'd1:    val = AMT_W'(2);
      default: val = AMT_W'(1);
    endcase
  endfunction

  // Ascending scan so the largest eligible denomination wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (val(3'(i)) <= r_rem && r_inv[i] != '0) begin
        w_found = 1'b1;
        w_pick  = 3'(i);
      end
    end
  end

  assign w_tmo_hit = (r_tmo == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.req_valid) w_next = S_SELECT;
      S_SELECT:   w_next = (r_rem != '0 && w_found) ? S_EJECT : S_DONE;
      S_EJECT:    w_next = S_WAIT_ACK;
      S_WAIT_ACK: if (bus.coin_ack || w_tmo_hit) w_next = S_SELECT;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_sel   <= '0;
      r_short <= '0;
      r_fault <= 1'b0;
      r_tmo   <= '0;
      r_tally <= '0;
      for (int i = 0; i < 5; i++) r_inv[i] <= INV_W'(INIT_INV);
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.refill) begin
            for (int i = 0; i < 5; i++) r_inv[i] <= INV_W'(INIT_INV);
            r_fault <= 1'b0;
          end
          if (bus.req_valid) begin
            r_rem   <= bus.req_amount;
            r_tally <= '0;
          end
        end
        S_SELECT: begin
          if (r_rem == '0)  r_short <= '0;
          else if (w_found) r_sel   <= w_pick;
          else              r_short <= r_rem;
        end
        S_EJECT: r_tmo <= '0;
        S_WAIT_ACK: begin
          if (bus.coin_ack) begin
            r_rem          <= r_rem - val(r_sel);
            r_inv[r_sel]   <= r_inv[r_sel] - INV_W'(1);
            r_tally[r_sel] <= r_tally[r_sel] + AMT_W'(1);
          end else if (w_tmo_hit) begin
            // Treat the stuck denomination as empty so the next smaller one is tried.
            r_inv[r_sel] <= '0;
            r_fault      <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = (r_state == S_IDLE);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = (r_state == S_DONE);
  assign bus.eject         = (r_state == S_EJECT) ? (5'b00001 << r_sel) : 5'b00000;
  assign bus.shortfall     = r_short;
  assign bus.fault         = r_fault;
  assign bus.tally_five    = r_tally[4];
  assign bus.tally_dollar  = r_tally[3];
  assign bus.tally_quarter = r_tally[2];
  assign bus.tally_dime    = r_tally[1];
  assign bus.tally_nickel  = r_tally[0];
endmodule
